node_input_arbiter: RTL
=======================

NODE_INPUT_ARBITER -- requirements
Module: node_input_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of an instruction word.
REQ-002 Parameter: FIFO_DEPTH, default 2, words buffered per input port; legal values 2, 4, 8.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: left_valid  input  1  word offered from the left neighbour (source code 2'b00).
REQ-006 Port: left_data  input  DATA_WIDTH  left neighbour word.
REQ-007 Port: left_ready  output  1  left FIFO can accept a word this cycle.
REQ-008 Port: local_valid / local_data / local_ready  input / input / output  1 / DATA_WIDTH / 1  local injection port (source code 2'b01).
REQ-009 Port: right_valid / right_data / right_ready  input / input / output  1 / DATA_WIDTH / 1  right neighbour port (source code 2'b10).
REQ-010 Port: controller_enable  output  1  registered; a new word is presented to the routing controller this cycle.
REQ-011 Port: source_port  output  2  registered; origin code of the presented word.
REQ-012 Port: instruction  output  DATA_WIDTH  registered; the presented word.

Function
REQ-013 Each port SHALL own an independent FIFO of FIFO_DEPTH words with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-014 <port>_ready SHALL be a combinational decode of the registered count: high iff count < FIFO_DEPTH.
REQ-015 A push SHALL occur on a rising edge iff <port>_valid && <port>_ready; data is captured at the write pointer, which wraps modulo FIFO_DEPTH.
REQ-016 valid while ready is low SHALL be ignored, with no push and no error state; the sender holds the word.
REQ-017 The downstream consumer has no backpressure; the arbiter SHALL grant at most one non-empty FIFO per cycle and pop it on the same edge.
REQ-018 Grant SHALL be round-robin. Pointer rr_ptr is in {0=left, 1=local, 2=right}. The search starts at rr_ptr and wraps 2->0. The first non-empty FIFO wins.
REQ-019 After a grant to port g, rr_ptr SHALL become (g+1) mod 3. With no grant, rr_ptr SHALL be unchanged.
REQ-020 Emptiness for arbitration SHALL use the registered count only; a word pushed on edge N is not grantable before edge N+1.
REQ-021 On a grant edge, the outputs SHALL register: controller_enable=1, source_port=code of g, instruction=head word of g.
REQ-022 On an edge with no grant, controller_enable SHALL register 0; source_port and instruction SHALL hold their previous values.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave the count unchanged and advance both pointers. This includes count==FIFO_DEPTH-1 and count==1.
REQ-024 A push to a full FIFO cannot occur (REQ-014); ready rises in the cycle after the pop that frees a slot.
REQ-025 source_port SHALL never be driven to 2'b11.
REQ-026 Minimum latency: a word pushed on edge N into an empty, top-priority FIFO SHALL appear with controller_enable=1 after edge N+1.
REQ-027 Sustained throughput SHALL be one word per cycle in aggregate. With all three ports saturated, each port is granted exactly once per 3 cycles.

Reset
REQ-028 While rst_n=0, asynchronously: all counts and pointers 0, rr_ptr=0, controller_enable=0, source_port=2'b00, instruction=0, all ready outputs high.
REQ-029 Reset asserted mid-operation SHALL discard all buffered words. No word SHALL be presented after release until a new push.
REQ-030 FIFO storage contents need not be reset.

Verification
REQ-031 After reset, push local_data=32'h2000_00AA once with the other ports idle -> one cycle later controller_enable=1, source_port=01, instruction=32'h2000_00AA; next cycle controller_enable=0.
REQ-032 All three ports push on the same edge with rr_ptr=0 -> the next three cycles present source_port 00, 01, 10 in order; rr_ptr ends at 0.
REQ-033 left_valid held high with 4 words for 6 cycles, other ports idle, FIFO_DEPTH=2 -> all 4 words are presented in order on consecutive cycles and left_ready never drops.
REQ-034 All ports held continuously valid for 30 cycles -> exactly 10 grants per port, strict 00/01/10 rotation, no word lost or duplicated.
REQ-035 Reset pulsed with 2 words buffered in the right FIFO -> after release, right_ready=1 and controller_enable stays 0 until a new push.
REQ-036 Fill the right FIFO (right_ready=0) while grants go to other ports, then release -> right_ready rises exactly one cycle after the first right pop.

Source files
------------

// File: rtl/node_input_arbiter.sv
// -----------------------------------------------------------------------------
// node_input_arbiter
//
// Purpose:
//   Collects instruction words arriving from three sources (left neighbour,
//   local injection, right neighbour). Each source has its own small FIFO.
//   A round-robin arbiter picks at most one non-empty FIFO per cycle, pops it,
//   and presents the word to the routing controller through registered
//   outputs. The downstream controller never stalls.
//
// Parameters:
//   DATA_WIDTH - width of one instruction word
//   FIFO_DEPTH - words buffered per source (2, 4 or 8)
//
// Ports:
//   clk               - clock, all state changes on the rising edge
//   rst_n             - asynchronous active-low reset
//   left_valid/_data  - word offered by the left neighbour   (source 2'b00)
//   left_ready        - left FIFO has room this cycle
//   local_valid/_data - word offered by local injection      (source 2'b01)
//   local_ready       - local FIFO has room this cycle
//   right_valid/_data - word offered by the right neighbour  (source 2'b10)
//   right_ready       - right FIFO has room this cycle
//   controller_enable - registered, a new word is presented this cycle
//   source_port       - registered, origin code of the presented word
//   instruction       - registered, the presented word
// -----------------------------------------------------------------------------
module node_input_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  left_valid,
    input  logic [DATA_WIDTH-1:0] left_data,
    output logic                  left_ready,

    input  logic                  local_valid,
    input  logic [DATA_WIDTH-1:0] local_data,
    output logic                  local_ready,

    input  logic                  right_valid,
    input  logic [DATA_WIDTH-1:0] right_data,
    output logic                  right_ready,

    output logic                  controller_enable,
    output logic [1:0]            source_port,
    output logic [DATA_WIDTH-1:0] instruction
);

    localparam int NUM_PORTS = 3;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Next index in the 0 -> 1 -> 2 -> 0 rotation; never yields 2'b11.
    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Per-port vectors, index 0 = left, 1 = local, 2 = right (equals the
    // source code presented on source_port).
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0]  in_valid;
    logic [NUM_PORTS-1:0]  in_ready;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  pop;
    logic [NUM_PORTS-1:0]  non_empty;
    logic [DATA_WIDTH-1:0] in_data   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] head_data [NUM_PORTS];

    assign in_valid   = {right_valid, local_valid, left_valid};
    assign in_data[0] = left_data;
    assign in_data[1] = local_data;
    assign in_data[2] = right_data;

    assign left_ready  = in_ready[0];
    assign local_ready = in_ready[1];
    assign right_ready = in_ready[2];

    // -------------------------------------------------------------------------
    // Input FIFOs. FIFO_DEPTH is a power of two, so the pointers wrap modulo
    // FIFO_DEPTH by natural overflow.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic [CNT_W-1:0]      count_next;

            // Ready and emptiness come only from the registered count, so a
            // word pushed this edge cannot be granted until the next one and
            // ready only rises the cycle after a pop frees a slot.
            assign in_ready[gi]  = (count_reg < DEPTH_CNT);
            assign non_empty[gi] = (count_reg != '0);
            assign push[gi]      = in_valid[gi] & in_ready[gi];
            assign head_data[gi] = mem[rd_ptr_reg];

            always_comb begin
                count_next = count_reg;
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;  // idle, or push+pop
                endcase
            end

            // Storage carries no reset; stale words are unreachable once the
            // count is cleared.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= in_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbitration: search starts at rr_ptr_reg and wraps 2 -> 0.
    // -------------------------------------------------------------------------
    logic [1:0] rr_ptr_reg;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic       grant_valid;
    logic [1:0] grant_idx;

    assign cand1 = inc3(rr_ptr_reg);
    assign cand2 = inc3(cand1);

    always_comb begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr_reg;
        if (non_empty[rr_ptr_reg]) begin
            grant_idx = rr_ptr_reg;
        end else if (non_empty[cand1]) begin
            grant_idx = cand1;
        end else if (non_empty[cand2]) begin
            grant_idx = cand2;
        end else begin
            grant_valid = 1'b0;
        end
    end

    // The granted FIFO is popped on the same edge its head is registered out.
    assign pop = grant_valid ? (3'b001 << grant_idx) : 3'b000;

    // -------------------------------------------------------------------------
    // Registered controller interface and round-robin pointer.
    // -------------------------------------------------------------------------
    logic                  controller_enable_reg;
    logic [1:0]            source_port_reg;
    logic [DATA_WIDTH-1:0] instruction_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg            <= 2'd0;
            controller_enable_reg <= 1'b0;
            source_port_reg       <= 2'b00;
            instruction_reg       <= '0;
        end else if (grant_valid) begin
            rr_ptr_reg            <= inc3(grant_idx);
            controller_enable_reg <= 1'b1;
            source_port_reg       <= grant_idx;
            instruction_reg       <= head_data[grant_idx];
        end else begin
            // No grant: pointer, source and word hold; only the strobe drops.
            controller_enable_reg <= 1'b0;
        end
    end

    assign controller_enable = controller_enable_reg;
    assign source_port       = source_port_reg;
    assign instruction       = instruction_reg;

endmodule
